// File: rtl/user_event_queue.sv
// Button front end for the game FSM: 2-FF sync, debounce, auto-repeat,
// priority arbitration and a show-ahead event FIFO.
package user_event_pkg;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_NEW_GAME = 3'd5
  } user_event_t;
endpackage

module user_event_queue
  import user_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  input  logic        btn_down_i,
  input  logic        btn_rotate_i,
  input  logic        btn_new_game_i,
  output user_event_t user_event_o,
  output logic        user_event_ready_o,
  input  logic        user_event_rd_req_i,
  output logic        drop_o
);

  // Handshake: user_event_o is valid while user_event_ready_o=1; a cycle with
  // user_event_rd_req_i=1 and user_event_ready_o=1 pops the head on the next edge.

  localparam int NB      = 5;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Bit order: 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROTATE, 4 NEW_GAME.
  logic [NB-1:0]   w_raw;
  logic [NB-1:0]   r_sync1;
  logic [NB-1:0]   r_sync2;
  logic [NB-1:0]   r_stable;
  logic [NB-1:0]   r_stable_d;
  logic [DB_W-1:0] r_db_cnt [NB];
  logic [NB-1:0]   w_press;
  logic [2:0]      w_rpt_req;
  logic [NB-1:0]   w_req;
  logic [NB-1:0]   r_pending;
  logic [NB-1:0]   w_sel;
  user_event_t     w_sel_ev;
  logic            w_wr;

  assign w_raw = {btn_new_game_i, btn_rotate_i, btn_down_i, btn_right_i, btn_left_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable[i] <= ~r_stable[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  for (genvar g = 0; g < 3; g++) begin : g_rpt
    rpt_state_t       r_state;
    rpt_state_t       w_next;
    logic [RPT_W-1:0] r_cnt;
    logic             w_expire;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= RPT_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_next;
        if (r_state == RPT_IDLE) begin
          r_cnt <= w_press[g] ? RPT_W'(REPEAT_DELAY) : '0;
        end else if (w_expire) begin
          r_cnt <= RPT_W'(REPEAT_PERIOD);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - RPT_W'(1);
        end
      end
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        RPT_IDLE:   if (w_press[g]) w_next = RPT_DELAY;
        RPT_DELAY:  begin
          if (!r_stable[g])  w_next = RPT_IDLE;
          else if (w_expire) w_next = RPT_REPEAT;
        end
        RPT_REPEAT: if (!r_stable[g]) w_next = RPT_IDLE;
        default:    w_next = RPT_IDLE;
      endcase
    end

    // Gating on the stable level keeps an expiry on the release cycle silent.
    always_comb begin
      w_expire = (r_state != RPT_IDLE) && r_stable[g] && (r_cnt == RPT_W'(1));
    end

    assign w_rpt_req[g] = w_expire;
  end

  assign w_req = w_press | {2'b00, w_rpt_req};

  always_comb begin
    w_sel    = '0;
    w_sel_ev = EV_NONE;
    if (r_pending[4]) begin
      w_sel = 5'b10000; w_sel_ev = EV_NEW_GAME;
    end else if (r_pending[3]) begin
      w_sel = 5'b01000; w_sel_ev = EV_ROTATE;
    end else if (r_pending[2]) begin
      w_sel = 5'b00100; w_sel_ev = EV_DOWN;
    end else if (r_pending[0]) begin
      w_sel = 5'b00001; w_sel_ev = EV_LEFT;
    end else if (r_pending[1]) begin
      w_sel = 5'b00010; w_sel_ev = EV_RIGHT;
    end
  end

  assign w_wr = |r_pending;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_sel) | w_req;
  end

  user_event_t      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_drop;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = user_event_rd_req_i & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = w_wr & (~w_full | w_pop);
  assign w_drop  = w_wr & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_sel_ev;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign user_event_ready_o = ~w_empty;
  assign user_event_o       = w_empty ? EV_NONE : r_mem[r_rd_ptr];
  assign drop_o             = r_drop;

endmodule

// File: tb/tb_user_event_queue.sv
// Bench for user_event_queue: directed scenarios plus randomized presses
// scored against an event-count model derived from hold durations.
module tb_user_event_queue;
  import user_event_pkg::*;

  localparam int D     = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_left, btn_right, btn_down, btn_rotate, btn_new_game;
  user_event_t ev;
  logic        ready;
  logic        drop;
  logic        rd_req;
  logic        drv_rd;
  logic        tie_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] exp_q[$];
  logic [2:0] got_ev[$];
  int         got_cyc[$];
  int         drop_cnt;

  assign rd_req = tie_rd ? ready : drv_rd;

  user_event_queue #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .btn_left_i(btn_left),
    .btn_right_i(btn_right),
    .btn_down_i(btn_down),
    .btn_rotate_i(btn_rotate),
    .btn_new_game_i(btn_new_game),
    .user_event_o(ev),
    .user_event_ready_o(ready),
    .user_event_rd_req_i(rd_req),
    .drop_o(drop)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop and drop monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (ready && rd_req) begin
        got_ev.push_back(ev);
        got_cyc.push_back(cyc);
      end
      if (drop) drop_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit order: 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROTATE, 4 NEW_GAME
  task automatic set_btns(input logic [4:0] b);
    {btn_new_game, btn_rotate, btn_down, btn_right, btn_left} = b;
  endtask

  task automatic pop_n(input int n);
    drv_rd = 1'b1;
    tick(n);
    drv_rd = 1'b0;
  endtask

  task automatic fill4();
    set_btns(5'b11011);
    tick(10);
    set_btns(5'b00000);
    tick(20);
  endtask

  function automatic logic [2:0] ev_of(input int b);
    case (b)
      0:       return EV_LEFT;
      1:       return EV_RIGHT;
      2:       return EV_DOWN;
      3:       return EV_ROTATE;
      default: return EV_NEW_GAME;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; drv_rd = 1'b0; tie_rd = 1'b0;
    set_btns(5'b00000);
    tick(3);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready); end
    checks++; if (ev !== EV_NONE) begin errors++; $display("FAIL reset_event: got %0d expected 0", ev); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b expected 0", drop); end
    rst = 1'b0;
    pop_n(3);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL empty_pop_ignored: ready got %0b expected 0", ready); end
  endtask

  task automatic test_rotate();
    set_btns(5'b01000);
    drv_rd = 1'b1;
    tick(7);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rotate_early: ready got %0b expected 0 at edge 7", ready); end
    tick(1);
    drv_rd = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rotate_latency: ready got %0b expected 1 at edge 8", ready); end
    checks++; if (ev !== EV_ROTATE) begin errors++; $display("FAIL rotate_event: got %0d expected %0d", ev, EV_ROTATE); end
    tick(22);
    set_btns(5'b00000);
    tick(30);
    got_ev.delete();
    pop_n(4);
    checks++; if (got_ev.size() != 1) begin errors++; $display("FAIL rotate_single: entries got %0d expected 1", got_ev.size()); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rotate_drained: ready got %0b expected 0", ready); end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    set_btns(5'b00001);
    tick(3);
    set_btns(5'b00000);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (ready) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL glitch_no_event: ready cycles got %0d expected 0", seen); end
    set_btns(5'b00001);
    tick(4);
    set_btns(5'b00000);
    tick(3);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL min_press_early: ready got %0b expected 0", ready); end
    tick(1);
    checks++; if (ready !== 1'b1 || ev !== EV_LEFT) begin errors++; $display("FAIL min_press_event: ready %0b ev %0d expected 1 %0d", ready, ev, EV_LEFT); end
    tick(30);
    got_ev.delete();
    pop_n(4);
    checks++; if (got_ev.size() != 1) begin errors++; $display("FAIL min_press_count: got %0d expected 1", got_ev.size()); end
  endtask

  task automatic test_down_repeat();
    int c0;
    int exp_off;
    got_ev.delete(); got_cyc.delete();
    tie_rd = 1'b1;
    c0 = cyc;
    set_btns(5'b00100);
    tick(60);
    set_btns(5'b00000);
    tick(60);
    tie_rd = 1'b0;
    checks++; if (got_ev.size() != 6) begin errors++; $display("FAIL repeat_count: got %0d expected 6", got_ev.size()); end
    for (int i = 0; i < 6 && i < got_ev.size(); i++) begin
      exp_off = (i == 0) ? D + 4 : D + 4 + RD + (i - 1) * RP;
      checks++; if (got_ev[i] !== EV_DOWN) begin errors++; $display("FAIL repeat_event[%0d]: got %0d expected %0d", i, got_ev[i], EV_DOWN); end
      checks++; if (got_cyc[i] - c0 != exp_off) begin errors++; $display("FAIL repeat_time[%0d]: got %0d expected %0d", i, got_cyc[i] - c0, exp_off); end
    end
  endtask

  task automatic test_simultaneous();
    exp_q = '{EV_NEW_GAME, EV_ROTATE, EV_LEFT, EV_RIGHT};
    got_ev.delete();
    drop_cnt = 0;
    fill4();
    pop_n(6);
    checks++; if (got_ev.size() != exp_q.size()) begin errors++; $display("FAIL simul_count: got %0d expected %0d", got_ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ev.size(); i++) begin
      checks++; if (got_ev[i] !== exp_q[i]) begin errors++; $display("FAIL simul_order[%0d]: got %0d expected %0d", i, got_ev[i], exp_q[i]); end
    end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL simul_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_full_drop();
    drop_cnt = 0;
    fill4();
    set_btns(5'b00100);
    tick(6);
    set_btns(5'b00000);
    tick(20);
    checks++; if (drop_cnt != 1) begin errors++; $display("FAIL full_drop_pulse: cycles got %0d expected 1", drop_cnt); end
    exp_q = '{EV_NEW_GAME, EV_ROTATE, EV_LEFT, EV_RIGHT};
    got_ev.delete();
    pop_n(6);
    checks++; if (got_ev.size() != 4) begin errors++; $display("FAIL full_count: got %0d expected 4", got_ev.size()); end
    for (int i = 0; i < 4 && i < got_ev.size(); i++) begin
      checks++; if (got_ev[i] !== exp_q[i]) begin errors++; $display("FAIL full_order[%0d]: got %0d expected %0d", i, got_ev[i], exp_q[i]); end
    end

    fill4();
    drop_cnt = 0;
    got_ev.delete();
    set_btns(5'b00100);
    tick(7);
    drv_rd = 1'b1;
    tick(1);
    drv_rd = 1'b0;
    set_btns(5'b00000);
    tick(20);
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL full_pop_nodrop: cycles got %0d expected 0", drop_cnt); end
    exp_q = '{EV_NEW_GAME, EV_ROTATE, EV_LEFT, EV_RIGHT, EV_DOWN};
    pop_n(8);
    checks++; if (got_ev.size() != 5) begin errors++; $display("FAIL full_pop_count: got %0d expected 5", got_ev.size()); end
    for (int i = 0; i < 5 && i < got_ev.size(); i++) begin
      checks++; if (got_ev[i] !== exp_q[i]) begin errors++; $display("FAIL full_pop_order[%0d]: got %0d expected %0d", i, got_ev[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_flush();
    set_btns(5'b11010);
    tick(8);
    set_btns(5'b00000);
    tick(20);
    set_btns(5'b00001);
    tick(10);
    rst = 1'b1;
    tick(1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b expected 0", ready); end
    checks++; if (ev !== EV_NONE) begin errors++; $display("FAIL flush_event: got %0d expected 0", ev); end
    tick(1);
    rst = 1'b0;
    got_ev.delete();
    tick(7);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL held_early: ready got %0b expected 0", ready); end
    tick(1);
    checks++; if (ready !== 1'b1 || ev !== EV_LEFT) begin errors++; $display("FAIL held_press: ready %0b ev %0d expected 1 %0d", ready, ev, EV_LEFT); end
    set_btns(5'b00000);
    tick(30);
    pop_n(6);
    checks++; if (got_ev.size() != 1) begin errors++; $display("FAIL held_count: got %0d expected 1", got_ev.size()); end
  endtask

  task automatic test_random();
    int b, h, n, gap;
    exp_q.delete();
    got_ev.delete();
    drop_cnt = 0;
    for (int p = 0; p < 12; p++) begin
      b = $urandom_range(0, 4);
      h = $urandom_range(D, 64);
      n = 1;
      if (b <= 2) begin
        for (int k = 0; RD + k * RP < h; k++) n++;
      end
      repeat (n) exp_q.push_back(ev_of(b));
      set_btns(5'(1 << b));
      for (int t = 0; t < h; t++) begin
        drv_rd = 1'($urandom_range(0, 1));
        tick(1);
      end
      set_btns(5'b00000);
      gap = $urandom_range(D + 8, D + 24);
      for (int t = 0; t < gap; t++) begin
        drv_rd = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    pop_n(20);
    checks++; if (got_ev.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ev.size(); i++) begin
      checks++; if (got_ev[i] !== exp_q[i]) begin errors++; $display("FAIL random_event[%0d]: got %0d expected %0d", i, got_ev[i], exp_q[i]); end
    end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL random_drop: got %0d expected 0", drop_cnt); end
  endtask

  initial begin
    rst = 1'b1; drv_rd = 1'b0; tie_rd = 1'b0; drop_cnt = 0;
    set_btns(5'b00000);
    test_reset();
    test_rotate();
    test_glitch();
    test_down_repeat();
    test_simultaneous();
    test_full_drop();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/user_event_queue.md
Name: user_event_queue

Overview:
- Producer end of the user-event interface consumed by the game FSM.
- Turns raw, asynchronous push-button levels into debounced, auto-repeated user_event_t events.
- Buffers events in a small show-ahead FIFO, drained with the ready / rd_req handshake.
- Sits between the board button pins and the game logic's user_event_i / user_event_ready_i / user_event_rd_req_o ports.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synced level must differ from the stable level before the stable level changes.
- REPEAT_DELAY, 12500000: cycles a repeatable button must be held before the first repeat event.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat events.
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- btn_left_i  in  1  raw button level, active-high, asynchronous.
- btn_right_i  in  1  raw button level, active-high, asynchronous.
- btn_down_i  in  1  raw button level, active-high, asynchronous.
- btn_rotate_i  in  1  raw button level, active-high, asynchronous.
- btn_new_game_i  in  1  raw button level, active-high, asynchronous.
- user_event_o  out  user_event_t  FIFO head event; valid only while user_event_ready_o=1.
- user_event_ready_o  out  1  FIFO not empty.
- user_event_rd_req_i  in  1  pop the head this cycle.
- drop_o  out  1  one-cycle pulse: an event was discarded because the FIFO was full.

Behaviour:
- Reset is synchronous, active-high; rst_i is sampled on clk_i.
- Reset clears synchronizers, stable levels, debounce and repeat counters, repeat FSMs, pending bits, FIFO pointers and count.
- Output reset values: user_event_ready_o=0, user_event_o='0, drop_o=0.
- Reset mid-operation flushes all queued and pending events.
- A button held through reset is seen as a fresh press after reset.
- Synchronizer: 2-FF per button.
- Debounce, per button:
  - Counter increments while the synced level differs from the stable level; it clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the stable level toggles on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no change.
- Press detect: a 0->1 transition of the stable level raises a request for that button. Releases raise nothing.
- Auto-repeat (LEFT, RIGHT, DOWN only), per-button FSM:
  - IDLE -> DELAY on press; counter loaded with REPEAT_DELAY.
  - DELAY -> REPEAT on expiry; raise a request and load REPEAT_PERIOD.
  - REPEAT: each expiry raises a request and reloads REPEAT_PERIOD.
  - Any state -> IDLE as soon as the stable level falls.
  - ROTATE and NEW_GAME raise exactly one request per press.
- Pending bits, one per button:
  - Set by a request; cleared when the arbiter selects that button.
  - A request arriving while the bit is already set coalesces into it (no second event).
- Arbiter:
  - Selects at most one pending button per cycle.
  - Priority: NEW_GAME > ROTATE > DOWN > LEFT > RIGHT.
  - The selected event is written to the FIFO on the next edge.
- FIFO (show-ahead):
  - user_event_o = head entry; user_event_ready_o = !empty.
  - A pop occurs when user_event_rd_req_i=1 and ready=1; rd_req while empty is ignored.
  - Write while full with no simultaneous pop: the event is discarded, its pending bit still clears, and drop_o pulses for 1 cycle.
  - Write + pop while full: both occur and count is unchanged.
  - Write + rd_req while empty: the write occurs and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- Latency: an isolated press with a clean raw edge and an empty FIFO raises user_event_ready_o after exactly DEBOUNCE_CYCLES+4 rising edges, counting the first edge that samples the new raw level as edge 1.
- Per-button throughput: at most 1 event per press, plus repeats.
- Global throughput: at most 1 FIFO write per cycle.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4):
- Press btn_rotate_i for 30 cycles, no reads -> ready rises on edge 8; user_event_o=EV_ROTATE; exactly 1 entry; no repeat.
- btn_left_i glitch high for 3 cycles -> no event, stable level unchanged, ready stays 0.
- Hold btn_down_i for 60 cycles with rd_req tied to ready -> EV_DOWN at press, then repeats at press+20, +28, +36, +44, +52 (6 events total); none after release.
- Press NEW_GAME, ROTATE, LEFT and RIGHT on the same cycle -> FIFO order: EV_NEW_GAME, EV_ROTATE, EV_LEFT, EV_RIGHT on consecutive write cycles.
- Fill the FIFO with 4 events, no reads, then press DOWN -> drop_o pulses once and count stays 4; repeat the press with rd_req asserted on the write cycle -> no drop, EV_DOWN becomes the tail.
- Assert rst_i with 3 queued events and LEFT held -> ready=0 the next cycle; after release of reset, one EV_LEFT appears DEBOUNCE_CYCLES+4 edges later.
